demux_64_1_8_reg: RTL and testbench
===================================

DEMUX_64_1_8_REG -- requirements
Module: demux_64_1_8_reg

Interface
REQ-001 Parameters: none; all sizes SHALL come from the shared package constants (WIDTH=64, LANES=8, SEL_W=3).
REQ-002 Ports SHALL be: clk  input  1  single rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 d  input  64  write data to be steered to one lane.
REQ-005 s  input  3  destination lane select, 0..7.
REQ-006 in_valid  input  1  d/s valid this cycle.
REQ-007 in_ready  output  1  block can accept d/s this cycle.
REQ-008 y  output  [7:0][63:0]  registered lane data, y[i] is lane i.
REQ-009 y_valid  output  8  per-lane occupied flag.
REQ-010 y_ack  input  8  per-lane consumer acknowledge; frees lane i.
REQ-011 overflow  output  1  sticky overwrite flag (see Configuration).

Function
REQ-012 A write SHALL be accepted when in_valid and in_ready are both 1 at a rising clk edge.
REQ-013 An accepted write SHALL load y[s] with d and set y_valid[s] to 1 at that edge (latency 1 cycle); other lanes are untouched.
REQ-014 in_ready SHALL be combinational: 1 when y_valid[s]==0, or y_ack[s]==1, and reset==0; 0 otherwise.
REQ-015 y_ack[i] with y_valid[i]==1 SHALL clear y_valid[i] at the edge; y_ack[i] on an empty lane SHALL be ignored.
REQ-016 Simultaneous ack and accepted write to the same lane SHALL load new data and leave y_valid[s]=1 (write wins).
REQ-017 Acks on any number of lanes SHALL be processed in the same cycle, independent of the write.
REQ-018 y[i] SHALL retain its last value after ack; only y_valid[i] clears.
REQ-019 in_valid==0 SHALL cause no state change other than ack processing; d and s are don't-care.
REQ-020 Per-lane state SHALL be EMPTY (y_valid=0) or FULL (y_valid=1): EMPTY->FULL on write; FULL->EMPTY on ack without write; FULL->FULL on write+ack.

Reset
REQ-021 While reset is 1 at an edge: y=0 for all lanes, y_valid=8'h00, overflow=0.
REQ-022 While reset is 1, in_ready SHALL be 0; a write or ack presented in a reset cycle SHALL be dropped.
REQ-023 Reset mid-operation SHALL discard all lane contents; first acceptable write is in the cycle after reset deasserts.

Configuration
REQ-024 Macro DEMUX_OVERWRITE_EN SHALL select full-lane policy.
REQ-025 Without DEMUX_OVERWRITE_EN: writes to a FULL lane without ack stall (REQ-014); overflow SHALL be tied to 0.
REQ-026 With DEMUX_OVERWRITE_EN: in_ready SHALL be 1 whenever reset==0; a write to a FULL lane without same-cycle ack SHALL overwrite y[s] and set overflow to 1 until reset.

Structure
REQ-027 Package demux_pkg SHALL hold WIDTH, LANES, SEL_W and typedef lane_data_t (logic [WIDTH-1:0]) and lane_vec_t (logic [LANES-1:0]).
REQ-028 One sub-module decoder_3_8 (3-bit select plus enable to 8-bit one-hot) SHALL generate per-lane write enables; lane registers SHALL be generated per lane.

Verification
REQ-029 Reset then d=64'hDEAD_BEEF_0000_0001, s=3, in_valid=1 -> next cycle y[3]=64'hDEAD_BEEF_0000_0001, y_valid=8'h08, other y=0.
REQ-030 Fill lanes 0..7 with d=i -> y_valid=8'hFF; write s=5 with no ack -> in_ready=0, y[5] stays 5 (non-overwrite build).
REQ-031 Lane 5 full, y_ack=8'h20 with write d=64'hFF, s=5 -> in_ready=1, next cycle y[5]=64'hFF, y_valid[5]=1.
REQ-032 y_ack=8'hFF with in_valid=0 on full block -> y_valid=8'h00, y values unchanged; ack on empty lane has no effect.
REQ-033 DEMUX_OVERWRITE_EN build: lane 2 full, write s=2 d=7 no ack -> y[2]=7, overflow=1 and stays 1; reset -> overflow=0.
REQ-034 Assert reset mid-stream with in_valid=1 -> in_ready=0, next cycle y_valid=8'h00, y all zero, no write recorded.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared sizes and lane types for the 64-bit 1:8 registered demux.
// Optional macro DEMUX_OVERWRITE_EN is consumed by demux_64_1_8_reg.
package demux_pkg;
  localparam int WIDTH = 64;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef logic [WIDTH-1:0] lane_data_t;
  typedef logic [LANES-1:0] lane_vec_t;
endpackage

// File: rtl/decoder_3_8.sv
// 3-bit select plus enable to 8-bit one-hot lane write enables.
// All outputs are zero when the enable is low.
module decoder_3_8
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output lane_vec_t        onehot_o
);

  // one bit per lane, only the selected lane is raised
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < LANES; i++) begin
      onehot_o[i] = en_i && (sel_i == SEL_W'(i));
    end
  end

endmodule

// File: rtl/demux_64_1_8_reg.sv
// Registered 64-bit 1:8 demux with per-lane valid/ack handshake.
// Macro DEMUX_OVERWRITE_EN: full lanes are overwritten and flag overflow.
module demux_64_1_8_reg
  import demux_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  lane_data_t                  d,
  input  logic [SEL_W-1:0]            s,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [LANES-1:0][WIDTH-1:0] y,
  output lane_vec_t                   y_valid,
  input  lane_vec_t                   y_ack,
  output logic                        overflow
);

  lane_vec_t vld_q;
  lane_vec_t we;
  logic      accept;

`ifdef DEMUX_OVERWRITE_EN
  assign in_ready = !reset;
`else
  assign in_ready = !reset && (!vld_q[s] || y_ack[s]);
`endif

  assign accept = in_valid && in_ready;

  decoder_3_8 u_dec (
    .sel_i    (s),
    .en_i     (accept),
    .onehot_o (we)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_data_t y_q, y_d;
    logic       v_q, v_d;

    // write wins over ack; ack on an empty lane is a no-op
    always_comb begin
      y_d = y_q;
      v_d = v_q;
      if (we[i]) begin
        y_d = d;
        v_d = 1'b1;
      end else if (y_ack[i]) begin
        v_d = 1'b0;
      end
    end

    // lane data and occupancy registers
    always_ff @(posedge clk) begin
      if (reset) begin
        y_q <= '0;
        v_q <= 1'b0;
      end else begin
        y_q <= y_d;
        v_q <= v_d;
      end
    end

    assign y[i]     = y_q;
    assign vld_q[i] = v_q;
  end

  assign y_valid = vld_q;

`ifdef DEMUX_OVERWRITE_EN
  logic ovf_q, ovf_d;

  // sticky: set by a write landing on a full lane that is not being freed
  always_comb begin
    ovf_d = ovf_q;
    if (accept && vld_q[s] && !y_ack[s]) begin
      ovf_d = 1'b1;
    end
  end

  // overflow flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_demux_64_1_8_reg.sv
// Self-checking bench for demux_64_1_8_reg against a lane-array model.
// Follows DEMUX_OVERWRITE_EN when the design is built with it.
module tb_demux_64_1_8_reg;

  logic            clk;
  logic            reset;
  logic [63:0]     d;
  logic [2:0]      s;
  logic            in_valid;
  logic            in_ready;
  logic [7:0][63:0] y;
  logic [7:0]      y_valid;
  logic [7:0]      y_ack;
  logic            overflow;

  logic [7:0][63:0] m_y;
  logic [7:0]       m_v;
  logic             m_ovf;

  int total = 0;
  int bad   = 0;

  demux_64_1_8_reg dut (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .s        (s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .y_valid  (y_valid),
    .y_ack    (y_ack),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_ready();
`ifdef DEMUX_OVERWRITE_EN
    return !reset;
`else
    return !reset && (!m_v[s] || y_ack[s]);
`endif
  endfunction

  task automatic drive(input logic r, input logic iv, input logic [2:0] sel,
                       input logic [63:0] data, input logic [7:0] ack);
    reset    = r;
    in_valid = iv;
    s        = sel;
    d        = data;
    y_ack    = ack;
    #1;
  endtask

  // advance one edge and apply the lane rules to the model
  task automatic tick();
    logic acc;
    logic was_full;
    @(posedge clk);
    if (reset) begin
      m_y   = '0;
      m_v   = '0;
      m_ovf = 1'b0;
    end else begin
      acc      = in_valid && exp_ready();
      was_full = m_v[s];
      for (int i = 0; i < 8; i++) begin
        if (acc && s == i) begin
          m_y[i] = d;
          m_v[i] = 1'b1;
        end else if (y_ack[i]) begin
          m_v[i] = 1'b0;
        end
      end
      if (acc && was_full && !y_ack[s]) m_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 3'd1, 64'h1234, 8'hFF);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got %b exp 0", in_ready);
    end
    tick();
    tick();
    total++;
    if (y_valid !== 8'h00) begin
      bad++;
      $display("FAIL reset_valid got %h exp 00", y_valid);
    end
    total++;
    if (y !== '0) begin
      bad++;
      $display("FAIL reset_y got %h exp 0", y);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got %b exp 0", overflow);
    end
  endtask

  task automatic test_single();
    logic [7:0][63:0] ey;
    ey = '0;
    ey[3] = 64'hDEAD_BEEF_0000_0001;
    drive(0, 1, 3'd3, 64'hDEAD_BEEF_0000_0001, 8'h00);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_ready got %b exp 1", in_ready);
    end
    tick();
    drive(0, 0, 3'd0, 64'h0, 8'h00);
    total++;
    if (y !== ey) begin
      bad++;
      $display("FAIL single_y got %h exp %h", y, ey);
    end
    total++;
    if (y_valid !== 8'h08) begin
      bad++;
      $display("FAIL single_valid got %h exp 08", y_valid);
    end
  endtask

  task automatic test_fill_stall();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 3'(i), 64'(i), 8'h00);
      tick();
    end
    drive(0, 0, 3'd0, 64'h0, 8'h00);
    total++;
    if (y_valid !== 8'hFF) begin
      bad++;
      $display("FAIL fill_valid got %h exp FF", y_valid);
    end
    total++;
    if (y !== m_y) begin
      bad++;
      $display("FAIL fill_y got %h exp %h", y, m_y);
    end
    drive(0, 1, 3'd5, 64'd99, 8'h00);
    total++;
`ifdef DEMUX_OVERWRITE_EN
    if (in_ready !== 1'b1) begin
`else
    if (in_ready !== 1'b0) begin
`endif
      bad++;
      $display("FAIL stall_ready got %b exp %b", in_ready, exp_ready());
    end
    tick();
    drive(0, 0, 3'd0, 64'h0, 8'h00);
    total++;
`ifdef DEMUX_OVERWRITE_EN
    if (y[5] !== 64'd99 || overflow !== 1'b1) begin
`else
    if (y[5] !== 64'd5 || overflow !== 1'b0) begin
`endif
      bad++;
      $display("FAIL stall_y5 got %h/%b exp %h/%b", y[5], overflow,
               m_y[5], m_ovf);
    end
  endtask

  task automatic test_ack_write();
    drive(0, 1, 3'd5, 64'hFF, 8'h20);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ackwr_ready got %b exp 1", in_ready);
    end
    tick();
    drive(0, 0, 3'd0, 64'h0, 8'h00);
    total++;
    if (y[5] !== 64'hFF || y_valid[5] !== 1'b1) begin
      bad++;
      $display("FAIL ackwr_y5 got %h/%b exp ff/1", y[5], y_valid[5]);
    end
    total++;
    if (y_valid !== m_v) begin
      bad++;
      $display("FAIL ackwr_valid got %h exp %h", y_valid, m_v);
    end
  endtask

  task automatic test_ack_all();
    logic [7:0][63:0] keep;
    keep = m_y;
    drive(0, 0, 3'd2, 64'h5555, 8'hFF);
    tick();
    total++;
    if (y_valid !== 8'h00 || y !== keep) begin
      bad++;
      $display("FAIL ackall got %h %h exp 00 %h", y_valid, y, keep);
    end
    drive(0, 0, 3'd0, 64'h0, 8'hA5);
    tick();
    total++;
    if (y_valid !== 8'h00 || y !== keep) begin
      bad++;
      $display("FAIL ackempty got %h %h exp 00 %h", y_valid, y, keep);
    end
  endtask

  task automatic test_overflow();
    drive(0, 1, 3'd2, 64'd1, 8'h00);
    tick();
    drive(0, 1, 3'd2, 64'd7, 8'h00);
    tick();
    drive(0, 0, 3'd0, 64'h0, 8'h00);
    tick();
    total++;
    if (overflow !== m_ovf || y[2] !== m_y[2]) begin
      bad++;
      $display("FAIL ovf_set got %b/%h exp %b/%h", overflow, y[2],
               m_ovf, m_y[2]);
    end
    drive(1, 0, 3'd0, 64'h0, 8'h00);
    tick();
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got %b exp 0", overflow);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 3'd6, 64'hABCD, 8'h00);
    tick();
    drive(1, 1, 3'd1, 64'h1111, 8'h00);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_ready got %b exp 0", in_ready);
    end
    tick();
    total++;
    if (y_valid !== 8'h00 || y !== '0) begin
      bad++;
      $display("FAIL rstmid_state got %h %h exp 00 0", y_valid, y);
    end
    drive(0, 1, 3'd1, 64'h2222, 8'h00);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_first got %b exp 1", in_ready);
    end
    tick();
    total++;
    if (y[1] !== 64'h2222 || y_valid !== 8'h02) begin
      bad++;
      $display("FAIL rstmid_wr got %h/%h exp 2222/02", y[1], y_valid);
    end
  endtask

  task automatic test_random();
    logic r;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 39) == 0);
      drive(r, 1'($urandom), 3'($urandom), {$urandom, $urandom},
            8'($urandom & $urandom));
      total++;
      if (in_ready !== exp_ready()) begin
        bad++;
        $display("FAIL rnd_ready n=%0d got %b exp %b", n, in_ready,
                 exp_ready());
      end
      tick();
      total++;
      if (y !== m_y || y_valid !== m_v || overflow !== m_ovf) begin
        bad++;
        $display("FAIL rnd_state n=%0d v=%h/%h o=%b/%b", n, y_valid, m_v,
                 overflow, m_ovf);
      end
    end
  endtask

  initial begin
    m_y   = '0;
    m_v   = '0;
    m_ovf = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0;
    s = '0;
    d = '0;
    y_ack = '0;
    test_reset();
    test_single();
    test_fill_stall();
    test_ack_write();
    test_ack_all();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
